// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS types and control-code constants.
package tmds_pkg;
  typedef logic signed [4:0] tally_t;
  typedef logic [9:0] sym_t;
  localparam sym_t CTL_00 = 10'b1101010100;
  localparam sym_t CTL_01 = 10'b0010101011;
  localparam sym_t CTL_10 = 10'b0101010100;
  localparam sym_t CTL_11 = 10'b1010101011;
  function automatic sym_t ctl_code(input logic [1:0] c);
    return c == 2'b00 ? CTL_00 : c == 2'b01 ? CTL_01 : c == 2'b10 ? CTL_10 : CTL_11;
  endfunction
endpackage

// File: rtl/tm_choice.sv
// tm_choice: transition-minimising stage, data byte -> 9-bit q_m.
module tm_choice (
  input  logic [7:0] data_in,
  output logic [8:0] q_m
);
  function automatic logic [8:0] tm(input logic [7:0] d);
    logic [3:0] n;
    logic xn;
    logic [8:0] q;
    n = 4'($countones(d));
    xn = n > 4'd4 || (n == 4'd4 && !d[0]);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i] ^ xn;
    q[8] = ~xn;
    return q;
  endfunction
  assign q_m = tm(data_in);
endmodule

// File: rtl/tmds_encoder.sv
// tmds_encoder: 8b/10b TMDS channel encoder, 1-cycle latency.
// Running-disparity balancing is built only when TMDS_DC_BALANCE_EN is defined.
module tmds_encoder
  import tmds_pkg::*;
(
  input  logic       pixel_clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic [1:0] control_in,
  input  logic       ve_in,
  output logic [9:0] tmds_out
);
  logic [8:0] q_m;
  sym_t sym_d, sym_q;
  tm_choice u_tm (.data_in(data_in), .q_m(q_m));
`ifdef TMDS_DC_BALANCE_EN
  tally_t tally_d, tally_q, diff;
  logic [3:0] n1q;
  logic [4:0] twice;
  // n1q - n0q == 2*n1q - 8; fits 5-bit signed
  assign n1q = 4'($countones(q_m[7:0]));
  assign twice = {n1q, 1'b0};
  assign diff = tally_t'(twice - 5'd8);
  always_comb begin
    sym_d = ctl_code(control_in);
    tally_d = '0;
    if (ve_in) begin
      if (tally_q == '0 || diff == '0) begin
        sym_d = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
        tally_d = q_m[8] ? tally_q + diff : tally_q - diff;
      end else if ((tally_q > 5'sd0 && diff > 5'sd0) || (tally_q < 5'sd0 && diff < 5'sd0)) begin
        sym_d = {1'b1, q_m[8], ~q_m[7:0]};
        tally_d = tally_q + (q_m[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
        sym_d = {1'b0, q_m[8], q_m[7:0]};
        tally_d = tally_q - (q_m[8] ? 5'sd0 : 5'sd2) + diff;
      end
    end
  end
  always_ff @(posedge pixel_clk_in) tally_q <= !rst_in ? '0 : tally_d;
`else
  assign sym_d = ve_in ? {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]} : ctl_code(control_in);
`endif
  always_ff @(posedge pixel_clk_in) sym_q <= !rst_in ? '0 : sym_d;
  assign tmds_out = sym_q;
endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: directed and randomized checks of tmds_encoder against a behavioural model.
module tb_tmds_encoder;
  logic clk = 0, rst_n = 0, ve = 0;
  logic [7:0] d = 0;
  logic [1:0] c = 0;
  logic [9:0] tmds_out;
  int cmp = 0, bad = 0, m_tally = 0, disp = 0;
  logic [9:0] exp_sym;

  tmds_encoder dut (.pixel_clk_in(clk), .rst_in(rst_n), .data_in(d), .control_in(c), .ve_in(ve), .tmds_out(tmds_out));
  always #5 clk = ~clk;

  function automatic int ones(input int v, input int w);
    int n = 0;
    for (int i = 0; i < w; i++) n += (v >> i) & 1;
    return n;
  endfunction

  function automatic int qm_of(input int x);
    int q, b;
    bit xn;
    xn = ones(x, 8) > 4 || (ones(x, 8) == 4 && (x & 1) == 0);
    q = x & 1;
    for (int i = 1; i < 8; i++) begin
      b = ((q >> (i - 1)) & 1) ^ ((x >> i) & 1) ^ int'(xn);
      q |= b << i;
    end
    return xn ? q : q | 256;
  endfunction

  // reference: what the symbol and tally should be after one clock with the current inputs
  task automatic model();
    int q, q8, n1, n0, lo;
    int ctl[4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    if (!rst_n) begin exp_sym = 0; m_tally = 0; return; end
    if (!ve) begin exp_sym = 10'(ctl[c]); m_tally = 0; return; end
    q = qm_of(int'(d)); q8 = q >> 8; lo = q & 255;
    n1 = ones(lo, 8); n0 = 8 - n1;
`ifdef TMDS_DC_BALANCE_EN
    if (m_tally == 0 || n1 == n0) begin
      exp_sym = 10'(((1 - q8) << 9) | (q8 << 8) | (q8 ? lo : 255 - lo));
      m_tally += q8 ? n1 - n0 : n0 - n1;
    end else if ((m_tally > 0 && n1 > n0) || (m_tally < 0 && n0 > n1)) begin
      exp_sym = 10'((1 << 9) | (q8 << 8) | (255 - lo));
      m_tally += 2 * q8 + n0 - n1;
    end else begin
      exp_sym = 10'((q8 << 8) | lo);
      m_tally += -2 * (1 - q8) + n1 - n0;
    end
`else
    exp_sym = 10'(((1 - q8) << 9) | (q8 << 8) | (q8 ? lo : 255 - lo));
`endif
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] dd, input logic [1:0] cc, input string tag);
    @(negedge clk);
    rst_n = r; ve = v; d = dd; c = cc;
    model();
    @(posedge clk); #1;
    cmp++;
    assert (tmds_out === exp_sym) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, tmds_out, exp_sym);
    end
`ifdef TMDS_DC_BALANCE_EN
    // cumulative disparity of emitted symbols must track the tally within a burst
    disp = (!r || !v) ? 0 : disp + 2 * ones(int'(tmds_out), 10) - 10;
    if (r && v) begin
      cmp++;
      assert (disp === m_tally && m_tally <= 10 && m_tally >= -10) else begin
        bad++;
        $error("FAIL %s_disp: got %0d expected %0d", tag, disp, m_tally);
      end
    end
`endif
  endtask

  task automatic lit(input logic [9:0] want, input string tag);
    cmp++;
    assert (tmds_out === want) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, tmds_out, want);
    end
  endtask

  initial begin
    int burst;
    step(0, 1, 8'hFF, 2'b11, "reset");
    lit(10'h000, "reset_lit");
    step(1, 1, 8'h00, 2'b00, "first00");
    lit(10'h100, "first00_lit");
    step(1, 1, 8'h00, 2'b00, "second00");
`ifdef TMDS_DC_BALANCE_EN
    lit(10'h3FF, "second00_lit");
`else
    lit(10'h100, "second00_lit");
`endif
    step(1, 0, 8'h5A, 2'b00, "ctl00"); lit(10'h354, "ctl00_lit");
    step(1, 0, 8'h5A, 2'b01, "ctl01"); lit(10'h0AB, "ctl01_lit");
    step(1, 0, 8'h5A, 2'b10, "ctl10"); lit(10'h154, "ctl10_lit");
    step(1, 0, 8'h5A, 2'b11, "ctl11"); lit(10'h2AB, "ctl11_lit");
    step(1, 1, 8'h00, 2'b00, "pre_rst");
    step(0, 1, 8'h00, 2'b00, "mid_rst"); lit(10'h000, "mid_rst_lit");
    step(1, 1, 8'h00, 2'b00, "post_rst"); lit(10'h100, "post_rst_lit");
    for (int i = 0; i < 32; i++) step(1, 1'(i & 1), 8'($urandom), 2'($urandom), "toggle");
    for (int k = 0; k < 7; k++) begin
      burst = 1280;
      for (int i = 0; i < burst; i++) step(1, 1, 8'($urandom), 2'b00, "active");
      for (int i = 0; i < int'($urandom_range(20, 160)); i++) step(1, 0, 8'($urandom), 2'($urandom), "blank");
    end
    for (int i = 0; i < 400; i++) step($urandom_range(0, 40) != 0, $urandom_range(0, 7) != 0, 8'($urandom), 2'($urandom), "mixed");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
